// File: rtl/ber_cmd_ctrl.sv
// Command controller between the soft-core GPIO and the I/Q PRBS9+BPSK BER datapaths.
// Decodes strobed GPO commands, drives TX/RX enables and offset, stretches a soft reset
// and returns coherent BER counter snapshots 32 bits at a time on GPI.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | waiting for a rising strobe on the registered GPO word
//  S_EXEC  | executing the latched opcode for one cycle
//  S_PULSE | holding o_sys_reset high while the pulse timer counts down
//  S_WAIT  | waiting for the strobe to drop before re-arming
module ber_cmd_ctrl #(
    parameter int NB_GPIOS   = 32,
    parameter int NB_CNT     = 64,
    parameter int RST_CYCLES = 16
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_GPIOS-1:0] i_gpo,
    input  logic [NB_CNT-1:0]   i_bit_count_i,
    input  logic [NB_CNT-1:0]   i_error_count_i,
    input  logic [NB_CNT-1:0]   i_bit_count_q,
    input  logic [NB_CNT-1:0]   i_error_count_q,
    output logic [NB_GPIOS-1:0] o_gpi,
    output logic                o_tx_enable,
    output logic                o_rx_enable,
    output logic [1:0]          o_offset,
    output logic                o_sys_reset,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_PULSE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_SRST   = 8'h01;
    localparam logic [7:0] OP_SET_TX = 8'h02;
    localparam logic [7:0] OP_SET_RX = 8'h03;
    localparam logic [7:0] OP_SETOFS = 8'h04;
    localparam logic [7:0] OP_SNAP   = 8'h05;
    localparam logic [7:0] OP_READ   = 8'h06;
    localparam logic [7:0] OP_STATUS = 8'h07;

    localparam logic [7:0] PULSE_LEN = 8'(RST_CYCLES);

    state_t              state;
    state_t              state_nx;
    logic [NB_GPIOS-1:0] gpo_q;
    logic                strb_d;
    logic                start;
    logic [7:0]          op;
    logic [2:0]          arg;
    logic [7:0]          pulse_cnt;

    logic [NB_CNT-1:0]   shd_bit_i;
    logic [NB_CNT-1:0]   shd_err_i;
    logic [NB_CNT-1:0]   shd_bit_q;
    logic [NB_CNT-1:0]   shd_err_q;
    logic [31:0]         rd_word;
    logic                shd_zero;
    logic                unused_gpo;

    // Only opcode, strobe and the low three argument bits carry meaning.
    assign unused_gpo = ^gpo_q[22:3];

    assign start  = (state == S_IDLE) && gpo_q[23] && !strb_d;
    assign o_busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            gpo_q  <= '0;
            strb_d <= 1'b0;
        end else begin
            gpo_q  <= i_gpo;
            strb_d <= gpo_q[23];
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_EXEC;
            S_EXEC:  state_nx = (op == OP_SRST) ? S_PULSE : S_WAIT;
            S_PULSE: if (pulse_cnt == 8'd1) state_nx = S_WAIT;
            S_WAIT:  if (!gpo_q[23]) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = 32'd0;
        case (arg)
            3'd0: rd_word = shd_bit_i[31:0];
            3'd1: rd_word = shd_bit_i[63:32];
            3'd2: rd_word = shd_err_i[31:0];
            3'd3: rd_word = shd_err_i[63:32];
            3'd4: rd_word = shd_bit_q[31:0];
            3'd5: rd_word = shd_bit_q[63:32];
            3'd6: rd_word = shd_err_q[31:0];
            3'd7: rd_word = shd_err_q[63:32];
            default: rd_word = 32'd0;
        endcase
    end

    assign shd_zero = (shd_err_i == '0) && (shd_err_q == '0);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            op          <= '0;
            arg         <= '0;
            pulse_cnt   <= '0;
            o_gpi       <= '0;
            o_tx_enable <= 1'b0;
            o_rx_enable <= 1'b0;
            o_offset    <= '0;
            o_sys_reset <= 1'b0;
            shd_bit_i   <= '0;
            shd_err_i   <= '0;
            shd_bit_q   <= '0;
            shd_err_q   <= '0;
        end else begin
            if (start) begin
                op  <= gpo_q[31:24];
                arg <= gpo_q[2:0];
            end

            if (state == S_EXEC) begin
                case (op)
                    OP_NOP: o_gpi <= 32'h0000_0000;
                    OP_SRST: begin
                        o_tx_enable <= 1'b0;
                        o_rx_enable <= 1'b0;
                        o_offset    <= 2'd0;
                        o_sys_reset <= 1'b1;
                        pulse_cnt   <= PULSE_LEN;
                        o_gpi       <= 32'h0000_0001;
                    end
                    OP_SET_TX: begin
                        o_tx_enable <= arg[0];
                        o_gpi       <= {op, 24'd0};
                    end
                    OP_SET_RX: begin
                        o_rx_enable <= arg[0];
                        o_gpi       <= {op, 24'd0};
                    end
                    OP_SETOFS: begin
                        o_offset <= arg[1:0];
                        o_gpi    <= {op, 24'd0};
                    end
                    OP_SNAP: begin
                        shd_bit_i <= i_bit_count_i;
                        shd_err_i <= i_error_count_i;
                        shd_bit_q <= i_bit_count_q;
                        shd_err_q <= i_error_count_q;
                        o_gpi     <= 32'h0000_0005;
                    end
                    OP_READ:   o_gpi <= rd_word;
                    OP_STATUS: o_gpi <= {24'd0, 3'd0, shd_zero, o_offset, o_rx_enable, o_tx_enable};
                    default:   o_gpi <= {16'hBAD0, 8'h00, op};
                endcase
            end

            // pulse_cnt holds the clocks still to go, so the last high cycle sees 1.
            if (state == S_PULSE) begin
                pulse_cnt <= pulse_cnt - 8'd1;
                if (pulse_cnt == 8'd1) o_sys_reset <= 1'b0;
            end
        end
    end

endmodule
